ha: RTL and testbench

Registered, lane-parallel half adder. Each of WIDTH independent lanes computes sum = a XOR b and carry-out = a AND b. Results are presented after a fixed, parameterised pipeline latency with a valid flag alongside. A saturating carry-event counter gives simple datapath observability. Used as a leaf arithmetic primitive and as a bring-up block for the team's simulation flow.

---
 rtl/ha.sv | 63 ++++++
 tb/tb_ha.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ha.sv
// Registered lane-parallel half adder with a LATENCY-deep pipeline
// and a saturating counter of samples that produced any carry.
module ha #(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] cout,
    output logic [CNT_W-1:0] carry_count
);

    logic             vld_q [LATENCY];
    logic [WIDTH-1:0] sum_q [LATENCY];
    logic [WIDTH-1:0] cy_q  [LATENCY];
    logic [CNT_W-1:0] cnt_q;

    logic             hit;
    logic             sat;

    assign hit = in_valid && (|(a & b));
    assign sat = (cnt_q == {CNT_W{1'b1}});

    // Data stages load every cycle; only valid qualifies them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                vld_q[k] <= 1'b0;
                sum_q[k] <= '0;
                cy_q[k]  <= '0;
            end
        end else begin
            vld_q[0] <= in_valid;
            sum_q[0] <= a ^ b;
            cy_q[0]  <= a & b;
            for (int k = 1; k < LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                sum_q[k] <= sum_q[k-1];
                cy_q[k]  <= cy_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (hit && !sat) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid   = vld_q[LATENCY-1];
    assign sum         = sum_q[LATENCY-1];
    assign cout        = cy_q[LATENCY-1];
    assign carry_count = cnt_q;

endmodule

// File: tb/tb_ha.sv
// Directed scoreboard bench for ha across three parameter sets
// sharing one stimulus stream.
module tb_ha;

    typedef struct packed {
        logic       v;
        logic [7:0] s;
        logic [7:0] c;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;

    logic       o1v, o3v, o4v;
    logic [0:0] o1s, o1c;
    logic [7:0] o3s, o3c;
    logic [3:0] o4s, o4c;
    logic [15:0] n1, n3;
    logic [1:0] n4;

    ent_t q1[$];
    ent_t q3[$];
    ent_t q4[$];
    int   c1, c3, c4;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ha #(.WIDTH(1), .LATENCY(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a[0:0]), .b(b[0:0]),
        .out_valid(o1v), .sum(o1s), .cout(o1c),
        .carry_count(n1)
    );

    ha #(.WIDTH(8), .LATENCY(3), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a), .b(b),
        .out_valid(o3v), .sum(o3s), .cout(o3c),
        .carry_count(n3)
    );

    ha #(.WIDTH(4), .LATENCY(2), .CNT_W(2)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a(a[3:0]), .b(b[3:0]),
        .out_valid(o4v), .sum(o4s), .cout(o4c),
        .carry_count(n4)
    );

    function automatic logic [7:0] lane_mask(input int w);
        logic [15:0] m;
        m = (16'd1 << w) - 16'd1;
        return m[7:0];
    endfunction

    function automatic ent_t mk(input int w, input logic v,
                                input logic [7:0] x, input logic [7:0] y);
        ent_t e;
        e.v = v;
        e.s = (x ^ y) & lane_mask(w);
        e.c = (x & y) & lane_mask(w);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic v,
                        input logic [7:0] x, input logic [7:0] y);
        ent_t e;
        rst      = r;
        in_valid = v;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        if (r) begin
            q1 = {};
            q3 = {};
            q4 = {};
            repeat (1) q1.push_back('0);
            repeat (3) q3.push_back('0);
            repeat (2) q4.push_back('0);
            c1 = 0;
            c3 = 0;
            c4 = 0;
        end else begin
            q1.push_back(mk(1, v, x, y));
            q3.push_back(mk(8, v, x, y));
            q4.push_back(mk(4, v, x, y));
            if (q1.size() > 1) void'(q1.pop_front());
            if (q3.size() > 3) void'(q3.pop_front());
            if (q4.size() > 2) void'(q4.pop_front());
            if (v && ((x & y & lane_mask(1)) != 0) && c1 < 65535) c1++;
            if (v && ((x & y & lane_mask(8)) != 0) && c3 < 65535) c3++;
            if (v && ((x & y & lane_mask(4)) != 0) && c4 < 3) c4++;
        end
        e = q1[0];
        chk("u1_valid", 16'(o1v), 16'(e.v));
        chk("u1_sum",   16'(o1s), 16'(e.s));
        chk("u1_cout",  16'(o1c), 16'(e.c));
        chk("u1_count", n1,       16'(c1));
        e = q3[0];
        chk("u3_valid", 16'(o3v), 16'(e.v));
        chk("u3_sum",   16'(o3s), 16'(e.s));
        chk("u3_cout",  16'(o3c), 16'(e.c));
        chk("u3_count", n3,       16'(c3));
        e = q4[0];
        chk("u4_valid", 16'(o4v), 16'(e.v));
        chk("u4_sum",   16'(o4s), 16'(e.s));
        chk("u4_cout",  16'(o4c), 16'(e.c));
        chk("u4_count", 16'(n4),  16'(c4));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        // reset held with valid carry-generating input: must be dropped
        step(1, 1, 8'hFF, 8'hFF);
        step(1, 1, 8'hFF, 8'hFF);
        step(1, 1, 8'hFF, 8'hFF);

        // per-lane truth table
        step(0, 1, 8'h00, 8'h00);
        step(0, 1, 8'h00, 8'h01);
        step(0, 1, 8'h01, 8'h00);
        step(0, 1, 8'h01, 8'h01);
        step(0, 0, 8'h00, 8'h00);
        chk("u1_tt_count", n1, 16'd1);

        // back-to-back wide samples
        step(0, 1, 8'hF0, 8'hCC);
        step(0, 1, 8'hFF, 8'h01);
        step(0, 0, 8'h00, 8'h00);
        chk("u3_s1_sum", 16'(o3s), 16'h003C);
        chk("u3_s1_cout", 16'(o3c), 16'h00C0);
        step(0, 0, 8'h00, 8'h00);
        chk("u3_s2_sum", 16'(o3s), 16'h00FE);
        chk("u3_s2_cout", 16'(o3c), 16'h0001);
        repeat (3) step(0, 0, 8'h00, 8'h00);

        // valid toggling through the pipe
        step(1, 0, 8'h00, 8'h00);
        step(0, 1, 8'hFF, 8'hFF);
        step(0, 0, 8'hFF, 8'hFF);
        step(0, 1, 8'hFF, 8'hFF);
        repeat (4) step(0, 0, 8'h00, 8'h00);
        chk("u3_toggle_count", n3, 16'd2);

        // reset while two samples are in flight
        step(0, 1, 8'h5A, 8'h3F);
        step(0, 1, 8'hA5, 8'hF3);
        step(1, 0, 8'h00, 8'h00);
        chk("u3_mid_rst_valid", 16'(o3v), 16'd0);
        chk("u3_mid_rst_count", n3, 16'd0);
        repeat (4) step(0, 0, 8'h00, 8'h00);

        // saturation of the 2-bit counter
        repeat (5) step(0, 1, 8'h0F, 8'h0F);
        chk("u4_sat_count", 16'(n4), 16'd3);
        repeat (4) step(0, $urandom_range(0, 1) == 1,
                        8'($urandom), 8'($urandom));
        repeat (3) step(0, 0, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
